// File: rtl/wb_stage_ext.sv
// Writeback stage: formats MEM/WB results (including sub-word loads), registers the
// register-file write port, keeps a short retired-write history and sequences halt.
module wb_stage_ext #(
    parameter int WIDTH      = 32,
    parameter int REGBITS    = 5,
    parameter int DEPTH      = 4,
    parameter int HALT_DELAY = 2
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               in_valid,
    input  logic               in_wen,
    input  logic [REGBITS-1:0] in_wsel,
    input  logic [1:0]         in_wdat_source,
    input  logic [WIDTH-1:0]   in_alu_result,
    input  logic [WIDTH-1:0]   in_dmemload,
    input  logic [WIDTH-1:0]   in_instr_npc,
    input  logic [1:0]         in_mem_size,
    input  logic               in_mem_unsigned,
    input  logic [1:0]         in_byte_off,
    input  logic               in_halt,
    output logic               WEN,
    output logic [REGBITS-1:0] wsel,
    output logic [WIDTH-1:0]   wdat,
    input  logic [REGBITS-1:0] fwd_sel,
    output logic               fwd_hit,
    output logic [WIDTH-1:0]   fwd_dat,
    output logic               halt
);

    localparam int CNT_W = (HALT_DELAY < 2) ? 1 : $clog2(HALT_DELAY + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               halted_q;
    logic               valid_q;
    logic               wen_q;
    logic [REGBITS-1:0] wsel_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   data_d;
    logic               wen_out;

    logic               hist_vld_q [DEPTH];
    logic [REGBITS-1:0] hist_sel_q [DEPTH];
    logic [WIDTH-1:0]   hist_dat_q [DEPTH];

    logic               fwd_hit_d;
    logic [WIDTH-1:0]   fwd_dat_d;

    // Half lanes use only off[1]; sub-words sign-extend unless uns is set.
    function automatic logic [WIDTH-1:0] load_extract(
        input logic [WIDTH-1:0] word,
        input logic [1:0]       size,
        input logic             uns,
        input logic [1:0]       off
    );
        logic [15:0]      half_v;
        logic [7:0]       byte_v;
        logic [WIDTH-1:0] res;
        half_v = off[1] ? word[31:16] : word[15:0];
        case (off)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        case (size)
            2'd1:    res = {{(WIDTH-16){half_v[15] & ~uns}}, half_v};
            2'd2:    res = {{(WIDTH-8){byte_v[7] & ~uns}}, byte_v};
            default: res = word;
        endcase
        return res;
    endfunction

    always_comb begin
        data_d = '0;
        case (in_wdat_source)
            2'd0:    data_d = in_alu_result;
            2'd1:    data_d = load_extract(in_dmemload, in_mem_size, in_mem_unsigned, in_byte_off);
            2'd2:    data_d = in_instr_npc;
            default: data_d = '0;
        endcase
    end

    assign wen_out = valid_q & wen_q & (wsel_q != '0);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            valid_q  <= 1'b0;
            wen_q    <= 1'b0;
            wsel_q   <= '0;
            data_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    valid_q <= in_valid;
                    wen_q   <= in_wen;
                    wsel_q  <= in_wsel;
                    data_q  <= data_d;
                    if (in_valid && in_halt) begin
                        state_q <= DRAIN;
                        cnt_q   <= CNT_W'(HALT_DELAY);
                    end
                end
                // The halting slot retires during the first DRAIN cycle; nothing new enters.
                DRAIN: begin
                    valid_q <= 1'b0;
                    if (cnt_q == '0) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                HALTED: begin
                    valid_q  <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) hist_vld_q[i] <= 1'b0;
        end else if (wen_out) begin
            for (int i = DEPTH - 1; i > 0; i--) hist_vld_q[i] <= hist_vld_q[i-1];
            hist_vld_q[0] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wen_out) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                hist_sel_q[i] <= hist_sel_q[i-1];
                hist_dat_q[i] <= hist_dat_q[i-1];
            end
            hist_sel_q[0] <= wsel_q;
            hist_dat_q[0] <= data_q;
        end
    end

    // Scan oldest to youngest so younger matches overwrite; the stage register wins last.
    always_comb begin
        fwd_hit_d = 1'b0;
        fwd_dat_d = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hist_vld_q[i] && (hist_sel_q[i] == fwd_sel)) begin
                fwd_hit_d = 1'b1;
                fwd_dat_d = hist_dat_q[i];
            end
        end
        if (wen_out && (wsel_q == fwd_sel)) begin
            fwd_hit_d = 1'b1;
            fwd_dat_d = data_q;
        end
        if (fwd_sel == '0) begin
            fwd_hit_d = 1'b0;
            fwd_dat_d = '0;
        end
    end

    assign WEN     = wen_out;
    assign wsel    = wsel_q;
    assign wdat    = data_q;
    assign fwd_hit = fwd_hit_d;
    assign fwd_dat = fwd_dat_d;
    assign halt    = halted_q;

endmodule

// File: tb/tb_wb_stage_ext.sv
// Bench for wb_stage_ext: vector table through a scoreboard, then forwarding,
// $zero, halt-drain and reset-during-drain sequences.
module tb_wb_stage_ext;
    localparam int WIDTH = 32, REGBITS = 5, DEPTH = 4, HALT_DELAY = 2;
    localparam logic [31:0] DML = 32'h80FF7F01;

    logic               CLK = 1'b0;
    logic               nRST;
    logic               in_valid, in_wen, in_mem_unsigned, in_halt;
    logic [REGBITS-1:0] in_wsel, fwd_sel;
    logic [1:0]         in_wdat_source, in_mem_size, in_byte_off;
    logic [WIDTH-1:0]   in_alu_result, in_dmemload, in_instr_npc;
    logic               WEN, fwd_hit, halt;
    logic [REGBITS-1:0] wsel;
    logic [WIDTH-1:0]   wdat, fwd_dat;

    always #5 CLK = ~CLK;

    wb_stage_ext #(.WIDTH(WIDTH), .REGBITS(REGBITS), .DEPTH(DEPTH), .HALT_DELAY(HALT_DELAY)) dut (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_wen(in_wen), .in_wsel(in_wsel),
        .in_wdat_source(in_wdat_source), .in_alu_result(in_alu_result), .in_dmemload(in_dmemload),
        .in_instr_npc(in_instr_npc), .in_mem_size(in_mem_size), .in_mem_unsigned(in_mem_unsigned),
        .in_byte_off(in_byte_off), .in_halt(in_halt), .WEN(WEN), .wsel(wsel), .wdat(wdat),
        .fwd_sel(fwd_sel), .fwd_hit(fwd_hit), .fwd_dat(fwd_dat), .halt(halt)
    );

    typedef struct {
        logic        v, w;
        logic [4:0]  sel;
        logic [1:0]  src;
        logic [31:0] alu, npc;
        logic [1:0]  sz;
        logic        u;
        logic [1:0]  off;
        logic        ew;
        logic [31:0] ed;
    } vec_t;

    typedef struct {
        logic        w;
        logic [4:0]  sel;
        logic [31:0] d;
    } exp_t;

    vec_t vecs[17];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mkv(input logic v, input logic w, input logic [4:0] sel,
                                 input logic [1:0] src, input logic [31:0] alu, input logic [31:0] npc,
                                 input logic [1:0] sz, input logic u, input logic [1:0] off,
                                 input logic ew, input logic [31:0] ed);
        vec_t r;
        r.v = v; r.w = w; r.sel = sel; r.src = src; r.alu = alu; r.npc = npc;
        r.sz = sz; r.u = u; r.off = off; r.ew = ew; r.ed = ed;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        in_valid = v.v; in_wen = v.w; in_wsel = v.sel; in_wdat_source = v.src;
        in_alu_result = v.alu; in_dmemload = DML; in_instr_npc = v.npc;
        in_mem_size = v.sz; in_mem_unsigned = v.u; in_byte_off = v.off; in_halt = 1'b0;
        e.w = v.ew; e.sel = v.sel; e.d = v.ed;
        sb.push_back(e);
    endtask

    task automatic retire(input string name);
        exp_t e;
        step();
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({name, "_wen"}, 32'(WEN), 32'(e.w));
            chk({name, "_wsel"}, 32'(wsel), 32'(e.sel));
            chk({name, "_wdat"}, wdat, e.d);
        end
    endtask

    task automatic wr(input string name, input logic v, input logic [4:0] sel, input logic [31:0] d);
        drive(mkv(v, 1'b1, sel, 2'd0, d, 32'h0, 2'd0, 1'b0, 2'd0, v && (sel != 5'd0), d));
        retire(name);
    endtask

    task automatic query(input string name, input logic [4:0] sel, input logic eh, input logic [31:0] ed);
        fwd_sel = sel;
        #1;
        chk({name, "_hit"}, 32'(fwd_hit), 32'(eh));
        chk({name, "_dat"}, fwd_dat, ed);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mkv(1, 1, 5'd5,  2'd0, 32'h1234, 0, 2'd0, 0, 2'd0, 1, 32'h00001234);
        vecs[1]  = mkv(1, 1, 5'd1,  2'd1, 0, 0, 2'd2, 0, 2'd3, 1, 32'hFFFFFF80);
        vecs[2]  = mkv(1, 1, 5'd2,  2'd1, 0, 0, 2'd2, 1, 2'd3, 1, 32'h00000080);
        vecs[3]  = mkv(1, 1, 5'd3,  2'd1, 0, 0, 2'd1, 0, 2'd2, 1, 32'hFFFF80FF);
        vecs[4]  = mkv(1, 1, 5'd4,  2'd1, 0, 0, 2'd1, 1, 2'd0, 1, 32'h00007F01);
        vecs[5]  = mkv(1, 1, 5'd6,  2'd1, 0, 0, 2'd1, 0, 2'd3, 1, 32'hFFFF80FF);
        vecs[6]  = mkv(1, 1, 5'd8,  2'd1, 0, 0, 2'd1, 0, 2'd1, 1, 32'h00007F01);
        vecs[7]  = mkv(1, 1, 5'd10, 2'd1, 0, 0, 2'd2, 0, 2'd0, 1, 32'h00000001);
        vecs[8]  = mkv(1, 1, 5'd11, 2'd1, 0, 0, 2'd2, 0, 2'd2, 1, 32'hFFFFFFFF);
        vecs[9]  = mkv(1, 1, 5'd14, 2'd1, 0, 0, 2'd2, 1, 2'd1, 1, 32'h0000007F);
        vecs[10] = mkv(1, 1, 5'd15, 2'd1, 0, 0, 2'd0, 0, 2'd2, 1, 32'h80FF7F01);
        vecs[11] = mkv(1, 1, 5'd16, 2'd1, 0, 0, 2'd3, 0, 2'd1, 1, 32'h80FF7F01);
        vecs[12] = mkv(1, 1, 5'd17, 2'd2, 32'h1, 32'h404, 2'd0, 0, 2'd0, 1, 32'h00000404);
        vecs[13] = mkv(1, 1, 5'd18, 2'd3, 32'h5555, 32'h404, 2'd0, 0, 2'd0, 1, 32'h00000000);
        vecs[14] = mkv(1, 1, 5'd0,  2'd0, 32'hDEAD, 0, 2'd0, 0, 2'd0, 0, 32'h0000DEAD);
        vecs[15] = mkv(0, 1, 5'd19, 2'd0, 32'h77, 0, 2'd0, 0, 2'd0, 0, 32'h00000077);
        vecs[16] = mkv(1, 0, 5'd19, 2'd0, 32'h88, 0, 2'd0, 0, 2'd0, 0, 32'h00000088);

        nRST = 1'b0;
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        void'(sb.pop_back());
        fwd_sel = 5'd5;
        step();
        step();
        chk("rst_wen", 32'(WEN), 32'd0);
        chk("rst_wsel", 32'(wsel), 32'd0);
        chk("rst_wdat", wdat, 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        query("rst_fwd", 5'd5, 1'b0, 32'd0);
        nRST = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i]);
            retire($sformatf("vec%0d", i));
        end

        // Forwarding priority: stage register over history, younger history over older.
        wr("r7a", 1, 5'd7, 32'hA);
        wr("r7b", 1, 5'd7, 32'hB);
        query("fwd_stage", 5'd7, 1'b1, 32'hB);
        wr("r9c", 1, 5'd9, 32'hC);
        wr("idle0", 0, 5'd0, 32'h0);
        query("fwd_r7", 5'd7, 1'b1, 32'hB);
        query("fwd_r9", 5'd9, 1'b1, 32'hC);
        query("fwd_r0", 5'd0, 1'b0, 32'h0);
        query("fwd_miss", 5'd12, 1'b0, 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) wr($sformatf("age%0d", i), 1, 5'(20 + i), 32'h100 + i);
        wr("idle1", 0, 5'd0, 32'h0);
        query("fwd_aged", 5'd7, 1'b0, 32'h0);
        query("fwd_old", 5'd21, 1'b1, 32'h101);

        // $zero write must not shift the history.
        wr("zero", 1, 5'd0, 32'hBAD);
        wr("idle2", 0, 5'd0, 32'h0);
        query("zero_hist", 5'd21, 1'b1, 32'h101);
        query("zero_q", 5'd0, 1'b0, 32'h0);

        // Same-cycle write and query sees only registered state.
        drive(mkv(1, 1, 5'd13, 2'd0, 32'h1313, 0, 0, 0, 0, 1, 32'h1313));
        query("same_cyc", 5'd13, 1'b0, 32'h0);
        retire("r13");
        query("r13_fwd", 5'd13, 1'b1, 32'h1313);

        // Halt drain.
        drive(mkv(1, 1, 5'd3, 2'd0, 32'h55, 0, 0, 0, 0, 1, 32'h55));
        in_halt = 1'b1;
        retire("halt_r3");
        chk("halt_r", 32'(halt), 32'd0);
        in_halt = 1'b0; in_valid = 1'b1; in_wen = 1'b1; in_wsel = 5'd4; in_alu_result = 32'h99;
        step();
        chk("drain1_wen", 32'(WEN), 32'd0);
        chk("drain1_halt", 32'(halt), 32'd0);
        step();
        chk("drain2_halt", 32'(halt), 32'd0);
        step();
        chk("drain3_halt", 32'(halt), 32'd1);
        chk("drain3_wen", 32'(WEN), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("sticky%0d_halt", i), 32'(halt), 32'd1);
            chk($sformatf("sticky%0d_wen", i), 32'(WEN), 32'd0);
        end

        nRST = 1'b0;
        step();
        chk("rst2_halt", 32'(halt), 32'd0);
        nRST = 1'b1;

        // Reset in the middle of a drain aborts it.
        drive(mkv(1, 1, 5'd3, 2'd0, 32'h66, 0, 0, 0, 0, 1, 32'h66));
        in_halt = 1'b1;
        retire("halt2_r3");
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        void'(sb.pop_back());
        step();
        #2;
        nRST = 1'b0;
        #1;
        chk("mid_rst_halt", 32'(halt), 32'd0);
        chk("mid_rst_wen", 32'(WEN), 32'd0);
        query("mid_rst_fwd", 5'd3, 1'b0, 32'h0);
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post_rst%0d_halt", i), 32'(halt), 32'd0);
        end
        wr("post_rst_wr", 1, 5'd5, 32'h77);
        query("post_rst_fwd", 5'd5, 1'b1, 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
